// File: rtl/wr_channel_arbiter_pkg.sv
// Shared types for the memory write-channel arbiter and its helpers.
package wr_channel_arbiter_pkg;

    localparam int unsigned WR_TAG_W = 8;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } wr_arb_state_t;

endpackage

// File: rtl/wr_channel_arbiter_if.sv
// Memory write channel: line address, source tag, data and a valid/ready handshake.
interface wr_channel_arbiter_if
    import wr_channel_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned ADDR_W = 58
) ();

    logic [ADDR_W-1:0]   um_tx_wr_addr;
    logic [WR_TAG_W-1:0] um_tx_wr_tag;
    logic                um_tx_wr_valid;
    logic [DATA_W-1:0]   um_tx_data;
    logic                um_tx_wr_ready;

    modport master (
        output um_tx_wr_addr,
        output um_tx_wr_tag,
        output um_tx_wr_valid,
        output um_tx_data,
        input  um_tx_wr_ready
    );

    modport slave (
        input  um_tx_wr_addr,
        input  um_tx_wr_tag,
        input  um_tx_wr_valid,
        input  um_tx_data,
        output um_tx_wr_ready
    );

endinterface

// File: rtl/wr_channel_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, searching cyclically.
module wr_channel_arbiter_rr_pick #(
    parameter int unsigned NUM_SRC = 2,
    localparam int unsigned IDX_W  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    localparam int unsigned SW = IDX_W + 1;

    logic [SW-1:0] cand;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, ptr} + SW'(k);
            if (cand >= SW'(NUM_SRC)) begin
                cand = cand - SW'(NUM_SRC);
            end
            if (!any && req[cand]) begin
                any            = 1'b1;
                grant_idx      = cand[IDX_W-1:0];
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_channel_arbiter.sv
// Packet-granular round-robin sharing of the memory write channel between NUM_SRC
// sources, with per-source address generation and a registered output slice.
module wr_channel_arbiter
    import wr_channel_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned ADDR_W  = 58,
    parameter int unsigned OFFS_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_last,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_base_addr,
    input  logic [NUM_SRC-1:0]          src_clear,
    wr_channel_arbiter_if.master        um_tx,
    output logic [$clog2(NUM_SRC)-1:0]  grant_idx,
    output logic [31:0]                 beat_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

    wr_arb_state_t       state_q;
    logic [IDX_W-1:0]    grant_q;
    logic [NUM_SRC-1:0]  grant_oh_q;
    logic [IDX_W-1:0]    rr_q;
    logic [OFFS_W-1:0]   offs_q [NUM_SRC];
    logic                valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WR_TAG_W-1:0] tag_q;
    logic [DATA_W-1:0]   data_q;
    logic [31:0]         beat_cnt_q;

    logic [DATA_W-1:0]   data_a [NUM_SRC];
    logic [ADDR_W-1:0]   base_a [NUM_SRC];

    logic [NUM_SRC-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                slot_free;
    logic                accept;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign data_a[gi] = src_data[gi*DATA_W +: DATA_W];
        assign base_a[gi] = src_base_addr[gi*ADDR_W +: ADDR_W];
    end

    wr_channel_arbiter_rr_pick #(
        .NUM_SRC(NUM_SRC)
    ) u_pick (
        .req      (src_valid),
        .ptr      (rr_q),
        .grant_oh (pick_oh),
        .grant_idx(pick_idx),
        .any      (pick_any)
    );

    // The output slice can take a new beat whenever it is empty or draining this cycle.
    assign slot_free = ~valid_q | um_tx.um_tx_wr_ready;
    assign accept    = (state_q == BURST) & src_valid[grant_q] & slot_free;

    always_comb begin
        src_ready = '0;
        if (state_q == BURST && slot_free) begin
            src_ready = grant_oh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_q       <= '0;
            valid_q    <= 1'b0;
            addr_q     <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            beat_cnt_q <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                offs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ARB: begin
                    if (pick_any) begin
                        grant_q    <= pick_idx;
                        grant_oh_q <= pick_oh;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    if (accept && src_last[grant_q]) begin
                        rr_q    <= (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                        state_q <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase

            if (slot_free) begin
                valid_q <= accept;
                data_q  <= data_a[grant_q];
                tag_q   <= WR_TAG_W'(grant_q);
                addr_q  <= base_a[grant_q] + ADDR_W'(offs_q[grant_q]);
            end

            // A clear coinciding with an accepted beat wins; the beat already used the old offset.
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (src_clear[i]) begin
                    offs_q[i] <= '0;
                end else if (accept && grant_q == IDX_W'(i)) begin
                    offs_q[i] <= offs_q[i] + 1'b1;
                end
            end

            if (valid_q && um_tx.um_tx_wr_ready) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign um_tx.um_tx_wr_valid = valid_q;
    assign um_tx.um_tx_wr_addr  = addr_q;
    assign um_tx.um_tx_wr_tag   = tag_q;
    assign um_tx.um_tx_data     = data_q;
    assign grant_idx            = grant_q;
    assign beat_cnt             = beat_cnt_q;

endmodule

// File: tb/tb_wr_channel_arbiter.sv
// Scoreboard bench for wr_channel_arbiter: a source engine pushes expected beats as the
// DUT accepts them, a monitor pops and compares on each memory-side transfer.
module tb_wr_channel_arbiter;
    import wr_channel_arbiter_pkg::*;

    localparam int unsigned NS = 2;
    localparam int unsigned DW = 512;
    localparam int unsigned AW = 58;
    localparam int unsigned OW = 32;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NS-1:0]            src_valid = '0;
    logic [NS*DW-1:0]         src_data = '0;
    logic [NS-1:0]            src_last = '0;
    logic [NS-1:0]            src_ready;
    logic [NS*AW-1:0]         src_base_addr = '0;
    logic [NS-1:0]            src_clear = '0;
    logic [$clog2(NS)-1:0]    grant_idx;
    logic [31:0]              beat_cnt;

    wr_channel_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) um ();

    wr_channel_arbiter #(
        .NUM_SRC(NS),
        .DATA_W (DW),
        .ADDR_W (AW),
        .OFFS_W (OW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .src_base_addr(src_base_addr),
        .src_clear    (src_clear),
        .um_tx        (um),
        .grant_idx    (grant_idx),
        .beat_cnt     (beat_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    tag;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    logic [63:0]   obs_addr[$];
    int            obs_tag[$];
    int            obs_cyc[$];

    int n_cmp = 0;
    int n_err = 0;

    // Source models, owned by the engine except where the sequencer sets up a test.
    int            rem[NS], pkts[NS], plen[NS], bidx[NS], seq[NS];
    int            pause_at[NS], pause_len[NS], pause_left[NS], clr_off[NS];
    bit            clr_en[NS], clr_hit[NS];
    logic [OW-1:0] off_m[NS];
    logic [AW-1:0] base_m[NS];
    logic [NS-1:0] clr_now = '0;

    int          t2_tag[8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    logic [63:0] t2_addr[8] = '{64'h2000, 64'h2001, 64'h1003, 64'h1004,
                                64'h2002, 64'h2003, 64'h1005, 64'h1006};
    int          t2_gap[8]  = '{0, 1, 2, 1, 2, 1, 2, 1};
    logic [63:0] t4_addr[6] = '{64'h2000, 64'h2001, 64'h2002, 64'h2003, 64'h2000, 64'h2001};
    int          t5_tag[6]  = '{0, 0, 0, 0, 1, 1};
    logic [63:0] t5_addr[6] = '{64'h100B, 64'h100C, 64'h100D, 64'h100E, 64'h2002, 64'h2003};
    int          t6_tag[4]  = '{0, 0, 1, 1};
    logic [63:0] t6_addr[4] = '{64'h1000, 64'h1001, 64'h2000, 64'h2001};

    function automatic logic [DW-1:0] mk_data(input int s, input int q);
        logic [31:0] w;
        w = {4'(s), 28'(q)};
        return {(DW/32){w}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_obs(input string nm, input int k, input int tag, input logic [63:0] addr);
        if (obs_tag.size() > k) begin
            chk($sformatf("%s_tag%0d", nm, k), 64'(obs_tag[k]), 64'(tag));
            chk($sformatf("%s_addr%0d", nm, k), obs_addr[k], addr);
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_missing%0d: got %0d beats expected more than %0d", nm, k, obs_tag.size(), k);
        end
    endtask

    function automatic bit all_idle();
        bit r;
        r = (exp_q.size() == 0) && !um.um_tx_wr_valid && (src_valid == '0);
        for (int i = 0; i < NS; i++) begin
            if (rem[i] != 0 || pkts[i] != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        bit done;
        done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            @(negedge clk);
            if (all_idle()) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, maxc);
        end
        tick();
    endtask

    always begin : engine
        logic [NS-1:0] acc;
        beat_t         e;
        @(negedge clk);
        acc = '0;
        if (!rst) begin
            acc = src_valid & src_ready;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && clr_en[i] && off_m[i] == OW'(clr_off[i])) begin
                    src_clear[i] = 1'b1;
                    clr_en[i]    = 1'b0;
                    clr_hit[i]   = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            src_valid = '0;
            src_last  = '0;
            src_clear = '0;
            clr_now   = '0;
            exp_q.delete();
            for (int i = 0; i < NS; i++) begin
                rem[i] = 0; pkts[i] = 0; bidx[i] = 0; pause_left[i] = 0;
                off_m[i] = '0; clr_en[i] = 1'b0; clr_hit[i] = 1'b0;
            end
        end else begin
            src_clear = clr_now;
            for (int i = 0; i < NS; i++) begin
                if (clr_now[i]) off_m[i] = '0;
                if (acc[i]) begin
                    e.addr = base_m[i] + AW'(off_m[i]);
                    e.tag  = 8'(i);
                    e.data = mk_data(i, seq[i]);
                    exp_q.push_back(e);
                    off_m[i] = off_m[i] + 1'b1;
                    if (clr_hit[i]) begin
                        off_m[i]   = '0;
                        clr_hit[i] = 1'b0;
                    end
                    seq[i]++;
                    rem[i]--;
                    bidx[i]++;
                    if (bidx[i] == pause_at[i]) pause_left[i] = pause_len[i];
                end
                if (rem[i] == 0 && pkts[i] > 0) begin
                    rem[i] = plen[i];
                    pkts[i]--;
                    bidx[i] = 0;
                end
                if (rem[i] > 0 && pause_left[i] > 0) begin
                    src_valid[i] = 1'b0;
                    pause_left[i]--;
                end else begin
                    src_valid[i] = (rem[i] > 0);
                end
                src_data[i*DW +: DW] = mk_data(i, seq[i]);
                src_last[i] = (rem[i] == 1);
            end
            clr_now = '0;
        end
    end

    always @(negedge clk) begin : monitor
        beat_t e;
        if (!rst && um.um_tx_wr_valid && um.um_tx_wr_ready) begin
            obs_addr.push_back(64'(um.um_tx_wr_addr));
            obs_tag.push_back(int'(um.um_tx_wr_tag));
            obs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got beat tag %0d addr %h expected none", um.um_tx_wr_tag, um.um_tx_wr_addr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", 64'(um.um_tx_wr_addr), 64'(e.addr));
                chk("sb_tag", 64'(um.um_tx_wr_tag), 64'(e.tag));
                n_cmp++;
                if (um.um_tx_data !== e.data) begin
                    n_err++;
                    $display("FAIL sb_data: got %h expected %h (low 64 bits)", um.um_tx_data[63:0], e.data[63:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_obs();
        obs_addr.delete();
        obs_tag.delete();
        obs_cyc.delete();
    endtask

    initial begin : sequencer
        logic [63:0] snap_addr, snap_data;
        bit          seen;
        for (int i = 0; i < NS; i++) begin
            rem[i] = 0; pkts[i] = 0; plen[i] = 1; bidx[i] = 0; seq[i] = 0;
            pause_at[i] = -1; pause_len[i] = 0; pause_left[i] = 0; clr_off[i] = 0;
            clr_en[i] = 1'b0; clr_hit[i] = 1'b0; off_m[i] = '0;
        end
        base_m[0] = AW'(64'h1000);
        base_m[1] = AW'(64'h2000);
        src_base_addr = {base_m[1], base_m[0]};
        um.um_tx_wr_ready = 1'b1;
        rst = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(um.um_tx_wr_valid), 64'd0);
        chk("rst_addr", 64'(um.um_tx_wr_addr), 64'd0);
        chk("rst_tag", 64'(um.um_tx_wr_tag), 64'd0);
        chk("rst_data", um.um_tx_data[63:0], 64'd0);
        chk("rst_src_ready", 64'(src_ready), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single 3-beat packet from source 0
        clear_obs();
        plen[0] = 3; pkts[0] = 1;
        wait_idle("t1", 60);
        chk("t1_count", 64'(obs_tag.size()), 64'd3);
        for (int k = 0; k < 3; k++) chk_obs("t1", k, 0, 64'h1000 + 64'(k));
        for (int k = 1; k < 3 && k < obs_cyc.size(); k++)
            chk($sformatf("t1_gap%0d", k), 64'(obs_cyc[k] - obs_cyc[k-1]), 64'd1);
        chk("t1_beat_cnt", 64'(beat_cnt), 64'd3);

        // 2: both sources stream 2-beat packets; rr pointer is 1 after test 1
        clear_obs();
        plen[0] = 2; plen[1] = 2; pkts[0] = 2; pkts[1] = 2;
        wait_idle("t2", 120);
        chk("t2_count", 64'(obs_tag.size()), 64'd8);
        for (int k = 0; k < 8; k++) chk_obs("t2", k, t2_tag[k], t2_addr[k]);
        for (int k = 1; k < 8 && k < obs_cyc.size(); k++)
            chk($sformatf("t2_gap%0d", k), 64'(obs_cyc[k] - obs_cyc[k-1]), 64'(t2_gap[k]));
        chk("t2_beat_cnt", 64'(beat_cnt), 64'd11);

        // 3: memory stalls for 5 cycles mid-packet
        clear_obs();
        plen[0] = 4; pkts[0] = 1;
        seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (um.um_tx_wr_valid) seen = 1'b1;
        end
        chk("t3_started", 64'(seen), 64'd1);
        tick();
        um.um_tx_wr_ready = 1'b0;
        snap_addr = '0;
        snap_data = '0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 0) begin
                snap_addr = 64'(um.um_tx_wr_addr);
                snap_data = um.um_tx_data[63:0];
            end else begin
                chk($sformatf("t3_hold_addr%0d", j), 64'(um.um_tx_wr_addr), snap_addr);
                chk($sformatf("t3_hold_data%0d", j), um.um_tx_data[63:0], snap_data);
            end
            chk($sformatf("t3_hold_valid%0d", j), 64'(um.um_tx_wr_valid), 64'd1);
            chk($sformatf("t3_src_ready%0d", j), 64'(src_ready), 64'd0);
        end
        tick();
        um.um_tx_wr_ready = 1'b1;
        wait_idle("t3", 60);
        chk("t3_count", 64'(obs_tag.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk_obs("t3", k, 0, 64'h1007 + 64'(k));
        chk("t3_beat_cnt", 64'(beat_cnt), 64'd15);

        // 4: clear source 1 on the beat with offset 3
        clear_obs();
        clr_now[1] = 1'b1;
        tick();
        tick();
        clr_off[1] = 3; clr_en[1] = 1'b1;
        plen[1] = 4; pkts[1] = 1;
        wait_idle("t4a", 60);
        plen[1] = 2; pkts[1] = 1;
        wait_idle("t4b", 60);
        chk("t4_count", 64'(obs_tag.size()), 64'd6);
        for (int k = 0; k < 6; k++) chk_obs("t4", k, 1, t4_addr[k]);
        chk("t4_beat_cnt", 64'(beat_cnt), 64'd21);

        // 5: source 0 idles 10 cycles mid-packet while source 1 waits
        clear_obs();
        pause_at[0] = 2; pause_len[0] = 10;
        plen[0] = 4; pkts[0] = 1;
        plen[1] = 2; pkts[1] = 1;
        wait_idle("t5", 120);
        pause_at[0] = -1;
        chk("t5_count", 64'(obs_tag.size()), 64'd6);
        for (int k = 0; k < 6; k++) chk_obs("t5", k, t5_tag[k], t5_addr[k]);
        if (obs_cyc.size() > 2) chk("t5_hold_gap", 64'(obs_cyc[2] - obs_cyc[1]), 64'd11);
        chk("t5_beat_cnt", 64'(beat_cnt), 64'd27);

        // 6: reset in the middle of a source 0 packet with rr pointer at 1
        plen[0] = 1; pkts[0] = 1;
        wait_idle("t6a", 40);
        clear_obs();
        plen[0] = 8; pkts[0] = 1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (obs_tag.size() >= 2) seen = 1'b1;
        end
        chk("t6_midpkt", 64'(seen), 64'd1);
        tick();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_valid", 64'(um.um_tx_wr_valid), 64'd0);
        chk("t6_rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("t6_rst_src_ready", 64'(src_ready), 64'd0);
        chk("t6_rst_grant", 64'(grant_idx), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        clear_obs();
        plen[0] = 2; plen[1] = 2; pkts[0] = 1; pkts[1] = 1;
        wait_idle("t6b", 60);
        chk("t6_count", 64'(obs_tag.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk_obs("t6", k, t6_tag[k], t6_addr[k]);
        chk("t6_beat_cnt", 64'(beat_cnt), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wr_channel_arbiter.md
Name: wr_channel_arbiter

Overview:
Shares the single memory write channel (um_tx_wr_*) between NUM_SRC packet-oriented write sources, e.g. the k-means centroid-update writer and a status/statistics writer. Packets are delimited by a per-source last flag and are never interleaved. Arbitration between sources is round-robin at packet granularity. The block owns per-source write address generation (base + line offset), and its registered output stage drives the memory write interface.

Parameters:
NUM_SRC, 2, number of write sources (2..8)
DATA_W, 512, cache-line width in bits
ADDR_W, 58, memory line address width
OFFS_W, 32, per-source line offset counter width

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high; one clock domain only
src_valid  in  NUM_SRC  per-source beat valid
src_data  in  NUM_SRC*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W]
src_last  in  NUM_SRC  beat is the final beat of its packet
src_ready  out  NUM_SRC  beat accepted from source i when src_valid[i] & src_ready[i]
src_base_addr  in  NUM_SRC*ADDR_W  per-source result base address (runtime parameter)
src_clear  in  NUM_SRC  one-cycle pulse that zeroes source i's line offset (start of run)
um_tx_wr_addr  out  ADDR_W  write line address
um_tx_wr_tag  out  8  source index of the beat, zero-extended
um_tx_wr_valid  out  1  write beat valid
um_tx_data  out  DATA_W  write data
um_tx_wr_ready  in  1  memory accepts the beat when valid & ready
grant_idx  out  $clog2(NUM_SRC)  currently or last granted source (debug)
beat_cnt  out  32  total beats accepted by memory since reset (debug)

Behaviour:
- Reset values: um_tx_wr_valid=0, um_tx_wr_addr/tag/data=0, src_ready=0, grant_idx=0, beat_cnt=0, rr pointer=0, all offsets=0, state=ARB.
- State machine has two states.
  - ARB: src_ready all 0. If any src_valid is set, grant the first requester at or after rr pointer (cyclic search), register it in grant_idx, go to BURST. Otherwise stay in ARB.
  - BURST: src_ready[grant_idx] = (~um_tx_wr_valid | um_tx_wr_ready). All other src_ready are 0.
- Exit from BURST: on an accepted beat with src_last=1, set rr pointer = grant_idx+1 (mod NUM_SRC) and go to ARB. This gives exactly one bubble cycle between packets.
- Output register slice:
  - When (~um_tx_wr_valid | um_tx_wr_ready), load valid = (state==BURST & src_valid[g]), data = src_data[g], tag = g, addr = src_base_addr[g] + zero-extended offset[g].
  - Otherwise all outputs hold. Outputs never change while valid=1 and ready=0.
- Latency: a beat accepted at cycle t is presented on um_tx_wr_valid at cycle t+1. Full throughput is one beat/cycle within a packet.
- Offsets:
  - offset[g] increments by 1 on each accepted beat of source g. It wraps modulo 2^OFFS_W silently.
  - Address sum is modulo 2^ADDR_W.
- src_clear[i] coinciding with an accepted beat of source i: that beat uses the old offset; the clear wins and offset becomes 0. src_clear on a non-granted source affects only that source's offset.
- The grant is held for the whole packet even if the source deasserts valid mid-packet; no timeout. Other sources wait.
- Single requester: it is re-granted after each bubble. Simultaneous requests are served strictly in rotation.
- beat_cnt increments on um_tx_wr_valid & um_tx_wr_ready and wraps at 2^32.
- rst asserted mid-packet: the in-flight output beat is dropped, and the packet is abandoned with no completion.

Decomposition:
- kmeansTypes gains the constant WR_TAG_W=8 and a typedef wr_arb_state_t {ARB, BURST}.
- Sub-module rr_pick (combinational, NUM_SRC parameter): request vector + pointer -> one-hot grant + index, any-valid flag. It is reusable by the read-side arbiter.

Test Plan:
1. Reset, then source 0 sends a 3-beat packet with base 0x1000, ready=1 -> addrs 0x1000, 0x1001, 0x1002 on consecutive cycles, tag 0, beat_cnt=3.
2. Both sources continuously send 2-beat packets -> order src0, src1, src0, src1. One idle cycle between packets. No interleaving within a packet.
3. um_tx_wr_ready low for 5 cycles mid-packet -> output held stable, src_ready[g]=0 during the stall, no beat lost or duplicated.
4. src_clear[1] pulsed on the cycle source 1 has its 4th beat accepted (offset 3) -> that beat addr = base+3, next packet of source 1 starts at base+0.
5. Source 0 deasserts valid for 10 cycles mid-packet while source 1 requests -> source 1 gets no beats until source 0's last beat.
6. rst asserted mid-packet -> next cycle valid=0, offsets 0, beat_cnt=0. The first packet after reset comes from source 0.
